// File: rtl/dma_sequencer.sv
// dma_sequencer: drives an am2940 address generator (instr/datain, done) and runs the
// peripheral dreq/dack handshake plus memory strobes for one programmed block transfer.
// Optional feature macro: DMA_SEQUENCER_XFER_CNT_EN (builds the completed-word counter).
module dma_sequencer #(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter logic [2:0]  NOP_INSTR     = 3'b011
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  host_addr,
    input  logic [7:0]  host_count,
    input  logic [2:0]  host_mode,
    input  logic        host_dir,
    input  logic        done,
    input  logic        dreq,
    output logic [2:0]  instr,
    output logic [7:0]  datain,
    output logic        dack,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        busy,
    output logic        irq,
    output logic [15:0] xfer_cnt
);

    localparam int unsigned STROBE_W   = 4;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned CNT_W      = 16;
    localparam logic [STROBE_W-1:0] STROBE_LOAD = STROBE_W'(STROBE_CYCLES - 1);

    localparam logic [2:0] I_WR_CR  = 3'b000;
    localparam logic [2:0] I_REINIT = 3'b100;
    localparam logic [2:0] I_LD_AR  = 3'b101;
    localparam logic [2:0] I_LD_WR  = 3'b110;
    localparam logic [2:0] I_ENABLE = 3'b111;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_CR,
        S_LD_AR,
        S_LD_WR,
        S_REINIT,
        S_WAIT_REQ,
        S_XFER,
        S_STEP,
        S_FINISH
    } state_e;

    state_e              state_q, state_d;
    logic [STROBE_W-1:0] strobe_q, strobe_d;
    logic                last_q, last_d;
    logic [2:0]          mode_q, mode_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   count_q, count_d;
    logic                dir_q, dir_d;

    logic [2:0]          instr_q, instr_d;
    logic [DATA_W-1:0]   datain_q, datain_d;
    logic                dack_q, dack_d;
    logic                mem_rd_q, mem_rd_d;
    logic                mem_wr_q, mem_wr_d;
    logic                busy_q, busy_d;
    logic                irq_q, irq_d;

    // Next-state, shadow-register capture and strobe countdown
    always_comb begin
        state_d  = state_q;
        strobe_d = strobe_q;
        last_d   = last_q;
        mode_d   = mode_q;
        addr_d   = addr_q;
        count_d  = count_q;
        dir_d    = dir_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LD_CR;
                    mode_d  = host_mode;
                    addr_d  = host_addr;
                    count_d = host_count;
                    dir_d   = host_dir;
                    last_d  = 1'b0;
                end
            end
            S_LD_CR:  state_d = S_LD_AR;
            S_LD_AR:  state_d = S_LD_WR;
            S_LD_WR:  state_d = S_REINIT;
            S_REINIT: state_d = S_WAIT_REQ;
            S_WAIT_REQ: begin
                if (abort) begin
                    state_d = S_FINISH;
                end else if (dreq) begin
                    state_d  = S_XFER;
                    strobe_d = STROBE_LOAD;
                end
            end
            S_XFER: begin
                if (strobe_q == '0) begin
                    last_d  = done;
                    state_d = S_STEP;
                end else begin
                    strobe_d = strobe_q - STROBE_W'(1);
                end
            end
            S_STEP:   state_d = (last_q || abort) ? S_FINISH : S_WAIT_REQ;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode of the upcoming state, registered so outputs depend on state only
    always_comb begin
        instr_d  = NOP_INSTR;
        datain_d = '0;
        dack_d   = 1'b0;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        irq_d    = 1'b0;
        busy_d   = (state_d != S_IDLE);
        case (state_d)
            S_LD_CR: begin
                instr_d  = I_WR_CR;
                datain_d = {5'b0, mode_d};
            end
            S_LD_AR: begin
                instr_d  = I_LD_AR;
                datain_d = addr_d;
            end
            S_LD_WR: begin
                instr_d  = I_LD_WR;
                datain_d = count_d;
            end
            S_REINIT: instr_d = I_REINIT;
            S_XFER: begin
                dack_d   = 1'b1;
                mem_rd_d = dir_d;
                mem_wr_d = ~dir_d;
            end
            S_STEP:   instr_d = I_ENABLE;
            S_FINISH: irq_d   = 1'b1;
            default: ;
        endcase
    end

    // State, shadow and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            strobe_q <= '0;
            last_q   <= 1'b0;
            mode_q   <= '0;
            addr_q   <= '0;
            count_q  <= '0;
            dir_q    <= 1'b0;
            instr_q  <= NOP_INSTR;
            datain_q <= '0;
            dack_q   <= 1'b0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            busy_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            strobe_q <= strobe_d;
            last_q   <= last_d;
            mode_q   <= mode_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            dir_q    <= dir_d;
            instr_q  <= instr_d;
            datain_q <= datain_d;
            dack_q   <= dack_d;
            mem_rd_q <= mem_rd_d;
            mem_wr_q <= mem_wr_d;
            busy_q   <= busy_d;
            irq_q    <= irq_d;
        end
    end

`ifdef DMA_SEQUENCER_XFER_CNT_EN
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

    // Completed-word count: clears on an accepted start, bumps once per STEP, wraps
    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if (state_q == S_IDLE && start) begin
            xfer_cnt_d = '0;
        end else if (state_q == S_STEP) begin
            xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
        end
    end

    // Completed-word count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xfer_cnt_q <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
`else
    assign xfer_cnt = CNT_W'(0);
`endif

    assign instr  = instr_q;
    assign datain = datain_q;
    assign dack   = dack_q;
    assign mem_rd = mem_rd_q;
    assign mem_wr = mem_wr_q;
    assign busy   = busy_q;
    assign irq    = irq_q;

endmodule

// File: tb/tb_dma_sequencer.sv
// Bench for dma_sequencer: two instances (strobe length 2 and 4) share stimulus, each
// driving its own behavioural am2940 model; run outcomes are predicted from the host
// parameters (word count, final address, strobe totals, irq count).
// Honours DMA_SEQUENCER_XFER_CNT_EN for the expected xfer_cnt value.
module tb_dma_sequencer;

    localparam int unsigned STROBE0 = 2;
    localparam int unsigned STROBE1 = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  host_addr = '0;
    logic [7:0]  host_count = '0;
    logic [2:0]  host_mode = '0;
    logic        host_dir = 1'b0;
    logic        dreq = 1'b0;

    logic        done_v   [2];
    logic [2:0]  instr_v  [2];
    logic [7:0]  datain_v [2];
    logic        dack_v   [2];
    logic        mem_rd_v [2];
    logic        mem_wr_v [2];
    logic        busy_v   [2];
    logic        irq_v    [2];
    logic [15:0] xfer_cnt_v [2];

    int checks = 0;
    int errors = 0;

    // am2940 model state
    logic [2:0] cr_m [2] = '{3'd0, 3'd0};
    logic [7:0] ar_m [2] = '{8'd0, 8'd0};
    logic [7:0] wr_m [2] = '{8'd0, 8'd0};
    logic [7:0] wc_m [2] = '{8'd0, 8'd0};

    // per-run observation counters
    int n_step [2];
    int n_irq  [2];
    int n_dack [2];
    int n_rd   [2];
    int n_wr   [2];
    int run_len [2] = '{0, 0};

    // expectations for the current run
    logic [7:0] exp_addr;
    int         exp_words;
    logic       exp_dir;
    logic       exp_down;

    always #5 clk = ~clk;

    dma_sequencer #(.STROBE_CYCLES(STROBE0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .host_addr(host_addr), .host_count(host_count), .host_mode(host_mode),
        .host_dir(host_dir), .done(done_v[0]), .dreq(dreq),
        .instr(instr_v[0]), .datain(datain_v[0]), .dack(dack_v[0]),
        .mem_rd(mem_rd_v[0]), .mem_wr(mem_wr_v[0]), .busy(busy_v[0]),
        .irq(irq_v[0]), .xfer_cnt(xfer_cnt_v[0])
    );

    dma_sequencer #(.STROBE_CYCLES(STROBE1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .host_addr(host_addr), .host_count(host_count), .host_mode(host_mode),
        .host_dir(host_dir), .done(done_v[1]), .dreq(dreq),
        .instr(instr_v[1]), .datain(datain_v[1]), .dack(dack_v[1]),
        .mem_rd(mem_rd_v[1]), .mem_wr(mem_wr_v[1]), .busy(busy_v[1]),
        .irq(irq_v[1]), .xfer_cnt(xfer_cnt_v[1])
    );

    function automatic logic am_done(input logic [2:0] cr, input logic [7:0] wc,
                                     input logic [7:0] wr);
        case (cr[1:0])
            2'b00:   return wc == 8'd1;
            2'b11:   return 1'b0;
            default: return 8'(wc + 8'd1) == wr;
        endcase
    endfunction

    assign done_v[0] = am_done(cr_m[0], wc_m[0], wr_m[0]);
    assign done_v[1] = am_done(cr_m[1], wc_m[1], wr_m[1]);

    // Behavioural am2940: acts on instr/datain at each rising edge
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            case (instr_v[k])
                3'b000: cr_m[k] <= datain_v[k][2:0];
                3'b101: ar_m[k] <= datain_v[k];
                3'b110: wr_m[k] <= datain_v[k];
                3'b100: wc_m[k] <= (cr_m[k][1:0] == 2'b00) ? wr_m[k] : 8'h00;
                3'b111: begin
                    ar_m[k] <= cr_m[k][2] ? ar_m[k] - 8'd1 : ar_m[k] + 8'd1;
                    wc_m[k] <= (cr_m[k][1:0] == 2'b00) ? wc_m[k] - 8'd1 : wc_m[k] + 8'd1;
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int strobe_of(input int k);
        return (k == 0) ? int'(STROBE0) : int'(STROBE1);
    endfunction

    function automatic logic [15:0] exp_cnt(input int words);
`ifdef DMA_SEQUENCER_XFER_CNT_EN
        return 16'(words);
`else
        return 16'(words * 0);
`endif
    endfunction

    // Observation monitor: counts activity and checks every dack burst length
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (instr_v[k] == 3'b111) n_step[k]++;
            if (irq_v[k])    n_irq[k]++;
            if (dack_v[k])   n_dack[k]++;
            if (mem_rd_v[k]) n_rd[k]++;
            if (mem_wr_v[k]) n_wr[k]++;
            if (reset) begin
                run_len[k] = 0;
            end else if (dack_v[k]) begin
                run_len[k]++;
            end else if (run_len[k] != 0) begin
                check($sformatf("strobe_len_dut%0d", k), 32'(run_len[k]), 32'(strobe_of(k)));
                run_len[k] = 0;
            end
        end
    end

    // Program a run and check the four command cycles; returns at the REINIT negedge
    task automatic start_run(input logic [7:0] a, input logic [7:0] c, input logic [2:0] m,
                             input logic d);
        for (int k = 0; k < 2; k++) begin
            n_step[k] = 0; n_irq[k] = 0; n_dack[k] = 0; n_rd[k] = 0; n_wr[k] = 0;
        end
        exp_addr  = a;
        exp_words = int'(c);
        exp_dir   = d;
        exp_down  = m[2];
        host_addr = a; host_count = c; host_mode = m; host_dir = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        host_addr = 8'($urandom); host_count = 8'($urandom);
        host_mode = 3'($urandom); host_dir = 1'($urandom);
        for (int k = 0; k < 2; k++) begin
            check("ld_cr", {busy_v[k], instr_v[k], datain_v[k]}, {1'b1, 3'b000, 5'b0, m});
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) check("ld_ar", {instr_v[k], datain_v[k]}, {3'b101, a});
        @(negedge clk);
        for (int k = 0; k < 2; k++) check("ld_wr", {instr_v[k], datain_v[k]}, {3'b110, c});
        @(negedge clk);
        for (int k = 0; k < 2; k++) check("reinit", 32'(instr_v[k]), 32'(3'b100));
    endtask

    // Drive dreq (0 fixed low, 1 fixed high, 2 random) until both instances idle, then score
    task automatic finish_run(input int dmode);
        logic ended;
        ended = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (dmode == 2) dreq = ($urandom_range(0, 3) != 0);
            else            dreq = (dmode == 1);
            if (!busy_v[0] && !busy_v[1]) begin
                ended = 1'b1;
                break;
            end
        end
        check("run_timeout", 32'(ended), 32'd1);
        for (int k = 0; k < 2; k++) begin
            logic [7:0] ar_exp;
            int strobes;
            ar_exp  = exp_down ? 8'(exp_addr - 8'(exp_words)) : 8'(exp_addr + 8'(exp_words));
            strobes = exp_words * strobe_of(k);
            check($sformatf("words_dut%0d", k), 32'(n_step[k]), 32'(exp_words));
            check($sformatf("irq_cycles_dut%0d", k), 32'(n_irq[k]), 32'd1);
            check($sformatf("ar_end_dut%0d", k), 32'(ar_m[k]), 32'(ar_exp));
            check($sformatf("dack_cycles_dut%0d", k), 32'(n_dack[k]), 32'(strobes));
            check($sformatf("mem_rd_cycles_dut%0d", k), 32'(n_rd[k]), exp_dir ? 32'(strobes) : 32'd0);
            check($sformatf("mem_wr_cycles_dut%0d", k), 32'(n_wr[k]), exp_dir ? 32'd0 : 32'(strobes));
            check($sformatf("xfer_cnt_dut%0d", k), 32'(xfer_cnt_v[k]), 32'(exp_cnt(exp_words)));
            check($sformatf("idle_instr_dut%0d", k), 32'(instr_v[k]), 32'(3'b011));
        end
    endtask

    task automatic wait_dack0(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dack_v[0]) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset_outputs",
                  {instr_v[k], datain_v[k], dack_v[k], mem_rd_v[k], mem_wr_v[k], busy_v[k], irq_v[k]},
                  {3'b011, 8'h00, 5'b0});
            check("reset_xfer_cnt", 32'(xfer_cnt_v[k]), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        // basic 3-word periph->mem run
        dreq = 1'b1;
        start_run(8'h10, 8'h03, 3'b000, 1'b0);
        finish_run(1);
        check("t1_ar_end", 32'(ar_m[0]), 32'h13);

        // no request for 20 cycles, then raise dreq
        dreq = 1'b0;
        start_run(8'h20, 8'h02, 3'b000, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t2_wait_req",
                  {instr_v[0], dack_v[0], mem_rd_v[0], mem_wr_v[0], busy_v[0], irq_v[0]},
                  {3'b011, 5'b00010});
        end
        dreq = 1'b1;
        @(negedge clk);
        check("t2_dack_follows_dreq", {29'b0, dack_v[0], dack_v[1], mem_wr_v[0]}, 32'b111);
        finish_run(1);

        // abort in WAIT_REQ after one word (mode 11: done never asserts)
        dreq = 1'b1;
        start_run(8'h30, 8'h05, 3'b011, 1'b0);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (instr_v[0] == 3'b111) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("t3_step_seen", 32'(seen), 32'd1);
        end
        @(negedge clk);
        check("t3_in_wait_req", {29'b0, instr_v[0]}, 32'(3'b011));
        abort = 1'b1;
        dreq  = 1'b0;
        @(negedge clk);
        check("t3_irq_next", {30'b0, irq_v[0], busy_v[0]}, 32'b11);
        check("t3_xfer_cnt", 32'(xfer_cnt_v[0]), 32'(exp_cnt(1)));
        exp_words = 1;
        finish_run(0);
        abort = 1'b0;

        // start pulsed mid-transfer with different host values is ignored
        dreq = 1'b1;
        start_run(8'h40, 8'h03, 3'b000, 1'b0);
        wait_dack0("t4_dack_seen");
        host_addr = 8'hA5; host_count = 8'h09; host_mode = 3'b100; host_dir = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_run(1);

        // reset on the 2nd strobe cycle abandons the run immediately
        dreq = 1'b1;
        start_run(8'h50, 8'h04, 3'b000, 1'b0);
        wait_dack0("t5_dack_seen");
        @(negedge clk);
        check("t5_second_xfer", {31'b0, dack_v[0]}, 32'd1);
        reset = 1'b1;
        #1;
        check("t5_async_reset",
              {instr_v[0], dack_v[0], mem_rd_v[0], mem_wr_v[0], busy_v[0], irq_v[0]},
              {3'b011, 5'b0});
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t5_idle_after", {instr_v[0], busy_v[0], xfer_cnt_v[0]}, {3'b011, 1'b0, 16'h0});

        // mem->periph, decrementing address
        dreq = 1'b1;
        start_run(8'h80, 8'h03, 3'b100, 1'b1);
        finish_run(1);

        // randomized runs
        for (int r = 0; r < 6; r++) begin
            logic [7:0] a;
            logic [7:0] c;
            logic [2:0] m;
            logic d;
            a = 8'($urandom);
            c = 8'($urandom_range(1, 6));
            m = {1'($urandom), 2'($urandom_range(0, 2))};
            d = 1'($urandom);
            start_run(a, c, m, d);
            finish_run(2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
